// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory bundle: IR fields and flags in, strobes and selects out.
// instret_ld/instret_ld_val is a debug preload for the retired-instruction counter.
interface multicycle_control_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        mem_ready;
    logic        instret_ld;
    logic [31:0] instret_ld_val;

    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instret;

    modport master (
        input  opcode, funct3, funct7, zero, mem_ready, instret_ld, instret_ld_val,
        output mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
               alu_src_a, alu_src_b, alu_control, illegal, state, instret
    );

    modport slave (
        output opcode, funct3, funct7, zero, mem_ready, instret_ld, instret_ld_val,
        input  mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
               alu_src_a, alu_src_b, alu_control, illegal, state, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle sequencing FSM for the RV32 subset add/or/sll/andi/lw/sw/beq.
// Drives datapath mux selects, write strobes, ALU command and the memory handshake.
module multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic              clk,
    input logic              reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic        retire;
    logic [31:0] instret_q;

    logic       mr, mw, irw, pcw, pcs, rw, m2r, ill;
    logic [1:0] sa, sb;
    logic [3:0] alu;

    // State register plus the load/store flag latched in DECODE (IR is not re-read in MEM_ADDR)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= state_t'(RESET_STATE);
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    // Retired-instruction counter; counts on the edge leaving a retiring state, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret_q <= 32'd0;
        else if (bus.instret_ld)
            instret_q <= bus.instret_ld_val;
        else if (retire)
            instret_q <= instret_q + 32'd1;
    end

    // Next state, decode and per-state strobes/selects
    always_comb begin
        state_d    = FETCH;
        is_store_d = is_store_q;
        retire     = 1'b0;
        mr = 1'b0; mw = 1'b0; irw = 1'b0; pcw = 1'b0; pcs = 1'b0;
        rw = 1'b0; m2r = 1'b0; ill = 1'b0;
        sa = 2'b00; sb = 2'b00; alu = 4'b0000;
        case (state_q)
            FETCH: begin
                mr = 1'b1;
                sb = 2'b01;
                if (bus.mem_ready) begin
                    irw     = 1'b1;
                    pcw     = 1'b1;
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                // Branch target PC_old + imm lands in ALUOut for BRANCH to use
                sa = 2'b10;
                sb = 2'b10;
                is_store_d = (bus.opcode == 7'b0100011);
                case (bus.opcode)
                    7'b0110011: begin
                        if (bus.funct7 == 7'b0000000 &&
                            (bus.funct3 == 3'b000 || bus.funct3 == 3'b110 || bus.funct3 == 3'b001))
                            state_d = EXEC_R;
                        else
                            ill = 1'b1;
                    end
                    7'b0010011: begin
                        if (bus.funct3 == 3'b111) state_d = EXEC_I;
                        else                      ill = 1'b1;
                    end
                    7'b0000011, 7'b0100011: state_d = MEM_ADDR;
                    7'b1100011: begin
                        if (bus.funct3 == 3'b000) state_d = BRANCH;
                        else                      ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            EXEC_R: begin
                sa = 2'b01;
                sb = 2'b00;
                case (bus.funct3)
                    3'b110:  alu = 4'b0001;
                    3'b001:  alu = 4'b0011;
                    default: alu = 4'b0000;
                endcase
                state_d = ALU_WB;
            end
            EXEC_I: begin
                sa      = 2'b01;
                sb      = 2'b10;
                alu     = 4'b0010;
                state_d = ALU_WB;
            end
            ALU_WB: begin
                rw     = 1'b1;
                retire = 1'b1;
            end
            MEM_ADDR: begin
                sa      = 2'b01;
                sb      = 2'b10;
                state_d = is_store_q ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mr      = 1'b1;
                state_d = bus.mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                rw     = 1'b1;
                m2r    = 1'b1;
                retire = 1'b1;
            end
            MEM_WR: begin
                mw = 1'b1;
                if (bus.mem_ready) retire = 1'b1;
                else               state_d = MEM_WR;
            end
            BRANCH: begin
                sa     = 2'b01;
                sb     = 2'b00;
                alu    = 4'b0100;
                pcs    = 1'b1;
                pcw    = bus.zero;
                retire = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Everything reads zero while reset is held, so a pending request drops immediately
    always_comb begin
        bus.mem_read    = mr  & ~reset;
        bus.mem_write   = mw  & ~reset;
        bus.ir_write    = irw & ~reset;
        bus.pc_write    = pcw & ~reset;
        bus.pc_src      = pcs & ~reset;
        bus.reg_write   = rw  & ~reset;
        bus.mem_to_reg  = m2r & ~reset;
        bus.illegal     = ill & ~reset;
        bus.alu_src_a   = reset ? 2'b00 : sa;
        bus.alu_src_b   = reset ? 2'b00 : sb;
        bus.alu_control = reset ? 4'b0000 : alu;
        bus.state       = state_q;
        bus.instret     = instret_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: each instruction pushes its expected per-cycle trace (with the
// inputs to drive that cycle); drain pops one record per cycle and compares outputs.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [3:0] st;
        logic       mr, mw, irw, pcw, pcs, rw, m2r, ill;
        logic [1:0] sa, sb;
        logic [3:0] alu;
    } exp_t;

    typedef struct {
        logic       rdy;
        logic       z;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        exp_t       e;
    } cyc_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;

    cyc_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_instret = 32'd0;

    function automatic exp_t rec(input logic [3:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t e;
        e.st  = bus.state;     e.mr  = bus.mem_read;  e.mw  = bus.mem_write;
        e.irw = bus.ir_write;  e.pcw = bus.pc_write;  e.pcs = bus.pc_src;
        e.rw  = bus.reg_write; e.m2r = bus.mem_to_reg; e.ill = bus.illegal;
        e.sa  = bus.alu_src_a; e.sb  = bus.alu_src_b; e.alu = bus.alu_control;
        return e;
    endfunction

    function automatic void push(input logic rdy, input logic z, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7, input exp_t e);
        cyc_t c;
        c.rdy = rdy; c.z = z; c.op = op; c.f3 = f3; c.f7 = f7; c.e = e;
        sb_q.push_back(c);
    endfunction

    // FETCH (with stalls) and DECODE records common to every instruction
    function automatic void push_head(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                      input int fstall, input logic ill);
        exp_t e;
        for (int i = 0; i < fstall; i++) begin
            e = rec(4'd0); e.mr = 1'b1; e.sb = 2'b01;
            push(1'b0, 1'b0, op, f3, f7, e);
        end
        e = rec(4'd0); e.mr = 1'b1; e.sb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
        push(1'b1, 1'b0, op, f3, f7, e);
        e = rec(4'd1); e.sa = 2'b10; e.sb = 2'b10; e.ill = ill;
        push(1'b1, 1'b0, op, f3, f7, e);
    endfunction

    function automatic void push_instr(input int kind, input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [3:0] alu_exp,
                                       input int fstall, input int mstall, input logic zv);
        exp_t e;
        push_head(op, f3, f7, fstall, kind == K_ILL);
        case (kind)
            K_R: begin
                e = rec(4'd2); e.sa = 2'b01; e.alu = alu_exp; push(1'b1, 1'b0, op, f3, f7, e);
                e = rec(4'd4); e.rw = 1'b1;                     push(1'b1, 1'b0, op, f3, f7, e);
            end
            K_I: begin
                e = rec(4'd3); e.sa = 2'b01; e.sb = 2'b10; e.alu = 4'b0010; push(1'b1, 1'b0, op, f3, f7, e);
                e = rec(4'd4); e.rw = 1'b1;                                 push(1'b1, 1'b0, op, f3, f7, e);
            end
            K_LW: begin
                e = rec(4'd5); e.sa = 2'b01; e.sb = 2'b10; push(1'b1, 1'b0, op, f3, f7, e);
                for (int i = 0; i < mstall; i++) begin
                    e = rec(4'd6); e.mr = 1'b1; push(1'b0, 1'b0, op, f3, f7, e);
                end
                e = rec(4'd6); e.mr = 1'b1;              push(1'b1, 1'b0, op, f3, f7, e);
                e = rec(4'd7); e.rw = 1'b1; e.m2r = 1'b1; push(1'b1, 1'b0, op, f3, f7, e);
            end
            K_SW: begin
                e = rec(4'd5); e.sa = 2'b01; e.sb = 2'b10; push(1'b1, 1'b0, op, f3, f7, e);
                for (int i = 0; i < mstall; i++) begin
                    e = rec(4'd8); e.mw = 1'b1; push(1'b0, 1'b0, op, f3, f7, e);
                end
                e = rec(4'd8); e.mw = 1'b1; push(1'b1, 1'b0, op, f3, f7, e);
            end
            K_BEQ: begin
                e = rec(4'd9); e.sa = 2'b01; e.alu = 4'b0100; e.pcs = 1'b1; e.pcw = zv;
                push(1'b1, zv, op, f3, f7, e);
            end
            default: ;
        endcase
        if (kind != K_ILL) exp_instret = exp_instret + 32'd1;
    endfunction

    task automatic drain(input string tag);
        cyc_t c;
        exp_t got;
        int   n = 0;
        while (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            @(negedge clk);
            bus.mem_ready = c.rdy; bus.zero = c.z;
            bus.opcode = c.op; bus.funct3 = c.f3; bus.funct7 = c.f7;
            #1;
            got = sample();
            total++;
            if (got !== c.e) begin
                bad++;
                $display("FAIL %s cyc%0d: got=%h want=%h", tag, n, got, c.e);
            end
            n++;
        end
    endtask

    // One FETCH stall cycle to look at state and instret between instructions
    task automatic check_idle(input string tag);
        @(negedge clk);
        bus.mem_ready = 1'b0; bus.zero = 1'b0;
        #1;
        total++;
        if (bus.state !== 4'd0 || bus.instret !== exp_instret) begin
            bad++;
            $display("FAIL %s idle: state=%0d instret=%h want state=0 instret=%h",
                     tag, bus.state, bus.instret, exp_instret);
        end
    endtask

    task automatic release_reset(input string tag);
        exp_t want;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        want = rec(4'd0); want.mr = 1'b1; want.sb = 2'b01;
        total++;
        if (sample() !== want) begin
            bad++;
            $display("FAIL %s first_fetch: got=%h want=%h", tag, sample(), want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1; bus.zero = 1'b0;
        bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7 = 7'b0;
        bus.instret_ld = 1'b0; bus.instret_ld_val = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (sample() !== rec(4'd0) || bus.instret !== 32'd0) begin
                bad++;
                $display("FAIL reset_hold: got=%h instret=%h want=%h instret=0",
                         sample(), bus.instret, rec(4'd0));
            end
        end
        exp_instret = 32'd0;
        release_reset("reset");
    endtask

    task automatic test_add();
        push_instr(K_R, 7'b0110011, 3'b000, 7'b0, 4'b0000, 0, 0, 1'b0);
        drain("add");
        check_idle("add");
    endtask

    task automatic test_back_to_back();
        push_instr(K_R, 7'b0110011, 3'b110, 7'b0, 4'b0001, 0, 0, 1'b0);
        push_instr(K_R, 7'b0110011, 3'b001, 7'b0, 4'b0011, 0, 0, 1'b0);
        push_instr(K_I, 7'b0010011, 3'b111, 7'b0, 4'b0010, 0, 0, 1'b0);
        drain("or_sll_andi");
        check_idle("or_sll_andi");
    endtask

    task automatic test_lw_stall();
        push_instr(K_LW, 7'b0000011, 3'b010, 7'b0, 4'b0000, 2, 3, 1'b0);
        total++;
        if (sb_q.size() != 10) begin
            bad++;
            $display("FAIL lw_len: got=%0d want=10", sb_q.size());
        end
        drain("lw");
        check_idle("lw");
        push_instr(K_SW, 7'b0100011, 3'b010, 7'b0, 4'b0000, 0, 1, 1'b0);
        drain("sw");
        check_idle("sw");
    endtask

    task automatic test_beq();
        push_instr(K_BEQ, 7'b1100011, 3'b000, 7'b0, 4'b0100, 0, 0, 1'b1);
        drain("beq_taken");
        check_idle("beq_taken");
        push_instr(K_BEQ, 7'b1100011, 3'b000, 7'b0, 4'b0100, 1, 0, 1'b0);
        drain("beq_not");
        check_idle("beq_not");
    endtask

    task automatic test_illegal();
        push_instr(K_ILL, 7'b0110011, 3'b000, 7'b0100000, 4'b0000, 0, 0, 1'b0);
        drain("sub");
        check_idle("sub");
        push_instr(K_ILL, 7'b1111111, 3'b000, 7'b0, 4'b0000, 0, 0, 1'b0);
        drain("op7f");
        check_idle("op7f");
    endtask

    task automatic test_reset_mid_store();
        exp_t e;
        logic [6:0] op = 7'b0100011;
        push_head(op, 3'b010, 7'b0, 0, 1'b0);
        e = rec(4'd5); e.sa = 2'b01; e.sb = 2'b10; push(1'b1, 1'b0, op, 3'b010, 7'b0, e);
        e = rec(4'd8); e.mw = 1'b1;                push(1'b0, 1'b0, op, 3'b010, 7'b0, e);
        drain("sw_abort");
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        total++;
        if (bus.state !== 4'd8 || bus.mem_write !== 1'b1) begin
            bad++;
            $display("FAIL sw_abort_pre: state=%0d mem_write=%b want state=8 mem_write=1",
                     bus.state, bus.mem_write);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.mem_write !== 1'b0 || bus.state !== 4'd0 || bus.instret !== 32'd0) begin
            bad++;
            $display("FAIL sw_abort_rst: mem_write=%b state=%0d instret=%h want 0 0 0",
                     bus.mem_write, bus.state, bus.instret);
        end
        exp_instret = 32'd0;
        release_reset("sw_abort");
        push_instr(K_I, 7'b0010011, 3'b111, 7'b0, 4'b0010, 0, 0, 1'b0);
        drain("after_abort");
        check_idle("after_abort");
    endtask

    task automatic test_instret_wrap();
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.instret_ld = 1'b1; bus.instret_ld_val = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.instret_ld = 1'b0;
        exp_instret = 32'hFFFF_FFFF;
        check_idle("preload");
        push_instr(K_R, 7'b0110011, 3'b000, 7'b0, 4'b0000, 0, 0, 1'b0);
        drain("wrap_add");
        total++;
        if (exp_instret !== 32'd0) begin
            bad++;
            $display("FAIL wrap_model: got=%h want=0", exp_instret);
        end
        check_idle("wrap");
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_lw_stall();
        test_beq();
        test_illegal();
        test_reset_mid_store();
        test_instret_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
